avalon_mm_copy_master: RTL and testbench

- Avalon-MM master (initiator) that copies a block of 32-bit words from one region of an on-chip RAM slave to another.
- Drives the RAM's s1/s2-style slave port.
- Used by the alarm-clock firmware to move time/alarm tables without CPU load.
- Software-facing side is a start/len/busy/done command interface; bus side is pipelined Avalon-MM with waitrequest and readdatavalid, one transaction outstanding.

---
 rtl/avalon_mm_copy_master_if.sv | 37 +++
 rtl/avalon_mm_copy_master.sv | 119 +++++++++++
 tb/tb_avalon_mm_copy_master.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_mm_copy_master_if.sv
// Avalon-MM master/slave bundle used by the block-copy engine.
// Ports: address/read/write/writedata/byteenable (master out), waitrequest/readdata/readdatavalid (slave out).
interface avalon_mm_copy_master_if #(
   parameter int DW = 32,
   parameter int AW = 10
);
   logic [AW-1:0]   avm_address;
   logic            avm_read;
   logic            avm_write;
   logic [DW-1:0]   avm_writedata;
   logic [DW/8-1:0] avm_byteenable;
   logic            avm_waitrequest;
   logic [DW-1:0]   avm_readdata;
   logic            avm_readdatavalid;

   modport master (
      output avm_address,
      output avm_read,
      output avm_write,
      output avm_writedata,
      output avm_byteenable,
      input  avm_waitrequest,
      input  avm_readdata,
      input  avm_readdatavalid
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      input  avm_write,
      input  avm_writedata,
      input  avm_byteenable,
      output avm_waitrequest,
      output avm_readdata,
      output avm_readdatavalid
   );
endinterface

// File: rtl/avalon_mm_copy_master.sv
// Avalon-MM block copy master: reads len words from src, writes them to dst, one op outstanding.
// Ports: clk, reset_n (async low), start/src_addr/dst_addr/len in, busy/done out,
// avm (master modport), checksum out when AVALON_MM_COPY_CHECKSUM_EN is defined.
module avalon_mm_copy_master #(
   parameter int DW = 32,
   parameter int AW = 10,
   parameter int LW = 11
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [LW-1:0] len,
   output logic          busy,
   output logic          done,
`ifdef AVALON_MM_COPY_CHECKSUM_EN
   output logic [DW-1:0] checksum,
`endif
   avalon_mm_copy_master_if.master avm
);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      FIN
   } state_t;

   state_t        state;
   logic [AW-1:0] src_ptr;
   logic [AW-1:0] dst_ptr;
   logic [LW-1:0] cnt;

   assign avm.avm_byteenable = '1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         busy              <= 1'b0;
         done              <= 1'b0;
         avm.avm_read      <= 1'b0;
         avm.avm_write     <= 1'b0;
         avm.avm_address   <= '0;
         avm.avm_writedata <= '0;
         src_ptr           <= '0;
         dst_ptr           <= '0;
         cnt               <= '0;
`ifdef AVALON_MM_COPY_CHECKSUM_EN
         checksum          <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
`ifdef AVALON_MM_COPY_CHECKSUM_EN
                  checksum <= '0;
`endif
                  if (len != '0) begin
                     src_ptr         <= src_addr;
                     dst_ptr         <= dst_addr;
                     cnt             <= len;
                     avm.avm_address <= src_addr;
                     avm.avm_read    <= 1'b1;
                     busy            <= 1'b1;
                     state           <= RD_REQ;
                  end else begin
                     // Empty job: report completion without touching the bus
                     done  <= 1'b1;
                     state <= FIN;
                  end
               end
            end
            RD_REQ: begin
               if (!avm.avm_waitrequest) begin
                  avm.avm_read <= 1'b0;
                  state        <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (avm.avm_readdatavalid) begin
                  avm.avm_writedata <= avm.avm_readdata;
                  avm.avm_address   <= dst_ptr;
                  avm.avm_write     <= 1'b1;
`ifdef AVALON_MM_COPY_CHECKSUM_EN
                  checksum <= checksum + avm.avm_readdata;
`endif
                  state <= WR_REQ;
               end
            end
            WR_REQ: begin
               if (!avm.avm_waitrequest) begin
                  avm.avm_write <= 1'b0;
                  src_ptr       <= src_ptr + 1'b1;
                  dst_ptr       <= dst_ptr + 1'b1;
                  cnt           <= cnt - 1'b1;
                  if (cnt == LW'(1)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     avm.avm_address <= src_ptr + 1'b1;
                     avm.avm_read    <= 1'b1;
                     state           <= RD_REQ;
                  end
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_mm_copy_master.sv
// Directed bench for the Avalon-MM copy master against a behavioural RAM slave.
// Job table plus hand-written reset-abort and checksum sequences.
module tb_avalon_mm_copy_master;
   localparam int DW = 32;
   localparam int AW = 10;
   localparam int LW = 11;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] src_addr = '0;
   logic [AW-1:0] dst_addr = '0;
   logic [LW-1:0] len = '0;
   logic          busy;
   logic          done;
`ifdef AVALON_MM_COPY_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   avalon_mm_copy_master_if #(.DW(DW), .AW(AW)) bus ();

   avalon_mm_copy_master #(.DW(DW), .AW(AW), .LW(LW)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start),
      .src_addr(src_addr),
      .dst_addr(dst_addr),
      .len(len),
      .busy(busy),
      .done(done),
`ifdef AVALON_MM_COPY_CHECKSUM_EN
      .checksum(checksum),
`endif
      .avm(bus.master)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Behavioural RAM slave
   logic [DW-1:0] mem [1024];
   logic [DW-1:0] snap [1024];
   int            wcfg = 0;
   int            stall;
   logic          rdv;
   logic [DW-1:0] rdata;
   int            rd_n = 0;
   int            wr_n = 0;
   int            rd_q[$];
   int            stab_err = 0;
   int            both_err = 0;
   logic          held;
   logic [AW-1:0] h_addr;
   logic          h_rd, h_wr;
   logic [DW-1:0] h_data;

   assign bus.avm_waitrequest = (bus.avm_read | bus.avm_write) && (stall < wcfg);
   assign bus.avm_readdata = rdata;
   assign bus.avm_readdatavalid = rdv;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall <= 0;
         rdv   <= 1'b0;
         rdata <= '0;
         held  <= 1'b0;
      end else begin
         rdv  <= 1'b0;
         held <= 1'b0;
         if (held) begin
            if (bus.avm_address !== h_addr || bus.avm_read !== h_rd ||
                bus.avm_write !== h_wr || bus.avm_writedata !== h_data)
               stab_err++;
         end
         if (bus.avm_read && bus.avm_write) both_err++;
         if (bus.avm_read || bus.avm_write) begin
            if (bus.avm_waitrequest) begin
               stall  <= stall + 1;
               held   <= 1'b1;
               h_addr <= bus.avm_address;
               h_rd   <= bus.avm_read;
               h_wr   <= bus.avm_write;
               h_data <= bus.avm_writedata;
            end else begin
               stall <= 0;
               if (bus.avm_read) begin
                  rdv   <= 1'b1;
                  rdata <= mem[bus.avm_address];
                  rd_q.push_back(int'(bus.avm_address));
                  rd_n++;
               end
               if (bus.avm_write) begin
                  mem[bus.avm_address] = bus.avm_writedata;
                  wr_n++;
               end
            end
         end
      end
   end

   function automatic logic [DW-1:0] init_val(input int i);
      logic [DW-1:0] v;
      if (i < 4) v = DW'(i + 1) * 32'h11111111;
      else v = {16'hC0DE, 16'(i)};
      return v;
   endfunction

   task automatic init_mem();
      for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
   endtask

   task automatic run_job(input string nm, input int src, input int dst,
                          input int n, input int w, input int exp_done);
      int rel;
      int busy_bad;
      int data_bad;
      int ord_bad;
      logic seen;
      for (int i = 0; i < 1024; i++) snap[i] = mem[i];
      wcfg = w;
      rd_n = 0;
      wr_n = 0;
      rd_q.delete();
      stab_err = 0;
      both_err = 0;
      busy_bad = 0;
      @(negedge clk);
      if (busy !== 1'b0) busy_bad++;
      start    = 1'b1;
      src_addr = AW'(src);
      dst_addr = AW'(dst);
      len      = LW'(n);
      rel  = 0;
      seen = 1'b0;
      while (!seen && rel < 5000) begin
         @(negedge clk);
         rel++;
         start = 1'b0;
         if (done) seen = 1'b1;
         else if (busy !== 1'b1) busy_bad++;
      end
      check({nm, " done_seen"}, 64'(seen), 64'd1);
      check({nm, " done_cycle"}, 64'(rel), 64'(exp_done));
      check({nm, " busy_at_done"}, 64'(busy), 64'd0);
      check({nm, " busy_window"}, 64'(busy_bad), 64'd0);
      @(negedge clk);
      check({nm, " done_one_cycle"}, 64'(done), 64'd0);
      check({nm, " reads"}, 64'(rd_n), 64'(n));
      check({nm, " writes"}, 64'(wr_n), 64'(n));
      ord_bad = 0;
      for (int i = 0; i < rd_q.size(); i++)
         if (rd_q[i] != ((src + i) % 1024)) ord_bad++;
      check({nm, " read_order"}, 64'(ord_bad), 64'd0);
      data_bad = 0;
      for (int i = 0; i < n; i++)
         if (mem[(dst + i) % 1024] !== snap[(src + i) % 1024]) data_bad++;
      check({nm, " data"}, 64'(data_bad), 64'd0);
      check({nm, " stall_stable"}, 64'(stab_err), 64'd0);
      check({nm, " rd_wr_excl"}, 64'(both_err), 64'd0);
   endtask

   typedef struct {
      string nm;
      int    src;
      int    dst;
      int    n;
      int    w;
      int    exp_done;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int done_bad;
      vecs[0] = '{"basic4", 0, 100, 4, 0, 13};
      vecs[1] = '{"wait2", 200, 300, 2, 2, 15};
      vecs[2] = '{"wrap", 1022, 10, 4, 0, 13};
      vecs[3] = '{"len0", 0, 50, 0, 0, 1};
      vecs[4] = '{"wait1_5", 700, 900, 5, 1, 26};
      vecs[5] = '{"single", 512, 0, 1, 0, 4};

      init_mem();
      #12;
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst read", 64'(bus.avm_read), 64'd0);
      check("rst write", 64'(bus.avm_write), 64'd0);
      check("rst addr", 64'(bus.avm_address), 64'd0);
      check("rst wdata", 64'(bus.avm_writedata), 64'd0);
      check("byteenable", 64'(bus.avm_byteenable), 64'hF);
      @(negedge clk);
      reset_n = 1'b1;

      for (int k = 0; k < 6; k++) begin
         init_mem();
         run_job(vecs[k].nm, vecs[k].src, vecs[k].dst, vecs[k].n,
                 vecs[k].w, vecs[k].exp_done);
      end

      // Abort during the write of word 2 of 5, then rerun the whole job
      init_mem();
      wcfg = 0;
      @(negedge clk);
      start    = 1'b1;
      src_addr = AW'(30);
      dst_addr = AW'(600);
      len      = LW'(5);
      done_bad = 0;
      for (int r = 1; r <= 6; r++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) done_bad++;
      end
      check("abort in_wr", 64'(bus.avm_write), 64'd1);
      check("abort wr_addr", 64'(bus.avm_address), 64'd601);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort busy", 64'(busy), 64'd0);
      check("abort write", 64'(bus.avm_write), 64'd0);
      check("abort read", 64'(bus.avm_read), 64'd0);
      check("abort addr", 64'(bus.avm_address), 64'd0);
      check("abort wdata", 64'(bus.avm_writedata), 64'd0);
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         if (done) done_bad++;
      end
      reset_n = 1'b1;
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         if (done) done_bad++;
      end
      check("abort no_done", 64'(done_bad), 64'd0);
      init_mem();
      run_job("after_abort", 30, 600, 5, 0, 16);

`ifdef AVALON_MM_COPY_CHECKSUM_EN
      init_mem();
      mem[500] = 32'hFFFFFFFF;
      mem[501] = 32'h00000002;
      run_job("csum", 500, 510, 2, 0, 7);
      check("csum value", 64'(checksum), 64'h1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
